// File: rtl/passcode_lock.sv
// Keypad passcode controller: digit entry buffer, code check, retry lockout,
// timed auto-relock and user code change while unlocked.
//
// state   | meaning
// ENTRY   | collecting digits; Enter with a full buffer starts a check
// CHECK   | one-cycle compare of the buffer against the stored code
// OPEN    | unlocked; open timer counting down to auto-relock
// SET     | unlocked; buffer collects a new code, open timer frozen
// LOCKOUT | too many wrong entries; keys ignored until lock timer expires
module passcode_lock #(
    parameter int                  DIGITS       = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                  MAX_TRIES    = 3,
    parameter int                  LOCK_CYCLES  = 250_000_000,
    parameter int                  OPEN_CYCLES  = 500_000_000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    output logic [4*DIGITS-1:0]          display,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic [3:0]                   error_count,
    output logic                         unlocked,
    output logic                         locked_out,
    output logic                         setting
);

    localparam int CNT_W   = $clog2(DIGITS + 1);
    localparam int T_MAX   = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
    localparam int TIMER_W = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);

    localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DIGITS);
    localparam logic [3:0]         TRY_LIMIT = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_SET     = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [4*DIGITS-1:0]  code_q, code_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [4*DIGITS-1:0]  display_d;
    logic [CNT_W-1:0]     count_d;
    logic [3:0]           error_d;
    logic [3:0]           error_inc;
    logic                 unlocked_d, locked_out_d, setting_d;

    logic                 is_digit, is_clear, is_enter, is_change, is_lock;
    logic                 buf_full;
    logic [4*DIGITS-1:0]  shifted;

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_clear  = key_valid && (key_code == 4'hA);
    assign is_enter  = key_valid && (key_code == 4'hB);
    assign is_change = key_valid && (key_code == 4'hC);
    assign is_lock   = key_valid && (key_code == 4'hD);
    assign buf_full  = (digit_count == FULL_CNT);

    // A single-digit code has nothing to shift up; the new key replaces the buffer.
    generate
        if (DIGITS == 1) begin : g_shift_one
            assign shifted = key_code;
        end else begin : g_shift_many
            assign shifted = {display[4*DIGITS-5:0], key_code};
        end
    endgenerate

    assign error_inc = (error_count == 4'hF) ? 4'hF : error_count + 4'd1;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        timer_d   = timer_q;
        display_d = display;
        count_d   = digit_count;
        error_d   = error_count;

        case (state_q)
            S_ENTRY, S_SET: begin
                if (is_digit) begin
                    if (!buf_full) begin
                        display_d = shifted;
                        count_d   = digit_count + CNT_W'(1);
                    end
                end else if (is_clear) begin
                    display_d = '1;
                    count_d   = '0;
                end else if (is_enter && buf_full) begin
                    if (state_q == S_ENTRY) begin
                        state_d = S_CHECK;
                    end else begin
                        code_d    = display;
                        display_d = '1;
                        count_d   = '0;
                        timer_d   = OPEN_LOAD;
                        state_d   = S_OPEN;
                    end
                end else if (is_lock && (state_q == S_SET)) begin
                    display_d = '1;
                    count_d   = '0;
                    state_d   = S_ENTRY;
                end
            end

            S_CHECK: begin
                display_d = '1;
                count_d   = '0;
                if (display == code_q) begin
                    error_d = 4'd0;
                    timer_d = OPEN_LOAD;
                    state_d = S_OPEN;
                end else begin
                    error_d = error_inc;
                    if (error_inc >= TRY_LIMIT) begin
                        timer_d = LOCK_LOAD;
                        state_d = S_LOCKOUT;
                    end else begin
                        state_d = S_ENTRY;
                    end
                end
            end

            S_OPEN: begin
                // Relock (timeout or D) wins over a change-code request on the same edge.
                if ((timer_q == '0) || is_lock) begin
                    state_d = S_ENTRY;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                    if (is_change) begin
                        display_d = '1;
                        count_d   = '0;
                        state_d   = S_SET;
                    end
                end
            end

            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    error_d = 4'd0;
                    state_d = S_ENTRY;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            default: begin
                display_d = '1;
                count_d   = '0;
                state_d   = S_ENTRY;
            end
        endcase
    end

    assign unlocked_d   = (state_d == S_OPEN) || (state_d == S_SET);
    assign locked_out_d = (state_d == S_LOCKOUT);
    assign setting_d    = (state_d == S_SET);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_ENTRY;
            code_q      <= DEFAULT_CODE;
            timer_q     <= '0;
            display     <= '1;
            digit_count <= '0;
            error_count <= 4'd0;
            unlocked    <= 1'b0;
            locked_out  <= 1'b0;
            setting     <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            timer_q     <= timer_d;
            display     <= display_d;
            digit_count <= count_d;
            error_count <= error_d;
            unlocked    <= unlocked_d;
            locked_out  <= locked_out_d;
            setting     <= setting_d;
        end
    end

endmodule

// File: tb/tb_passcode_lock.sv
// Bench for passcode_lock: directed scenarios plus random keys, all checked every
// cycle against a queue/deadline model of the lock, with literal spot checks.
module tb_passcode_lock;

    localparam int          DIGITS    = 4;
    localparam int          MAX_TRIES = 3;
    localparam int          LOCK_C    = 20;
    localparam int          OPEN_C    = 10;
    localparam logic [15:0] DEF_CODE  = 16'h1234;

    logic        CLK;
    logic        RST;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] display;
    logic [2:0]  digit_count;
    logic [3:0]  error_count;
    logic        unlocked;
    logic        locked_out;
    logic        setting;

    passcode_lock #(
        .DIGITS(DIGITS), .DEFAULT_CODE(DEF_CODE), .MAX_TRIES(MAX_TRIES),
        .LOCK_CYCLES(LOCK_C), .OPEN_CYCLES(OPEN_C)
    ) dut (
        .CLK(CLK), .RST(RST), .key_valid(key_valid), .key_code(key_code),
        .display(display), .digit_count(digit_count), .error_count(error_count),
        .unlocked(unlocked), .locked_out(locked_out), .setting(setting)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: buffer as a queue of digits, code as a digit array, timers as absolute deadlines.
    typedef enum int {M_ENTRY, M_CHECK, M_OPEN, M_SET, M_LOCK} mode_t;
    mode_t  m_mode = M_ENTRY;
    int     m_buf[$];
    int     m_code[DIGITS];
    int     m_err = 0;
    longint cyc = 0;
    longint exit_at = 0;
    int     mk;
    bit     mv;
    bit     match;

    always @(posedge CLK) begin
        cyc++;
        mk = int'(key_code);
        mv = key_valid;
        if (RST) begin
            m_mode = M_ENTRY;
            m_buf.delete();
            m_err = 0;
            for (int i = 0; i < DIGITS; i++) m_code[i] = int'(DEF_CODE[4*(DIGITS-1-i) +: 4]);
        end else begin
            case (m_mode)
                M_ENTRY, M_SET: begin
                    if (mv && mk <= 9) begin
                        if (m_buf.size() < DIGITS) m_buf.push_back(mk);
                    end else if (mv && mk == 10) begin
                        m_buf.delete();
                    end else if (mv && mk == 11 && m_buf.size() == DIGITS) begin
                        if (m_mode == M_ENTRY) begin
                            m_mode = M_CHECK;
                        end else begin
                            for (int i = 0; i < DIGITS; i++) m_code[i] = m_buf[i];
                            m_buf.delete();
                            m_mode  = M_OPEN;
                            exit_at = cyc + OPEN_C;
                        end
                    end else if (mv && mk == 13 && m_mode == M_SET) begin
                        m_buf.delete();
                        m_mode = M_ENTRY;
                    end
                end
                M_CHECK: begin
                    match = 1'b1;
                    for (int i = 0; i < DIGITS; i++) if (m_buf[i] != m_code[i]) match = 1'b0;
                    m_buf.delete();
                    if (match) begin
                        m_err   = 0;
                        m_mode  = M_OPEN;
                        exit_at = cyc + OPEN_C;
                    end else begin
                        m_err = (m_err < 15) ? m_err + 1 : 15;
                        if (m_err >= MAX_TRIES) begin
                            m_mode  = M_LOCK;
                            exit_at = cyc + LOCK_C;
                        end else begin
                            m_mode = M_ENTRY;
                        end
                    end
                end
                M_OPEN: begin
                    if (cyc == exit_at || (mv && mk == 13)) begin
                        m_mode = M_ENTRY;
                    end else if (mv && mk == 12) begin
                        m_buf.delete();
                        m_mode = M_SET;
                    end
                end
                M_LOCK: begin
                    if (cyc == exit_at) begin
                        m_mode = M_ENTRY;
                        m_err  = 0;
                    end
                end
                default: m_mode = M_ENTRY;
            endcase
        end
    end

    logic [15:0] exp_disp;

    always @(negedge CLK) begin
        if (chk_en) begin
            exp_disp = '1;
            for (int i = 0; i < m_buf.size(); i++)
                exp_disp[4*(m_buf.size()-1-i) +: 4] = 4'(m_buf[i]);
            check("display", 32'(display), 32'(exp_disp));
            check("digit_count", 32'(digit_count), 32'(m_buf.size()));
            check("error_count", 32'(error_count), 32'(m_err));
            check("unlocked", 32'(unlocked), 32'(m_mode == M_OPEN || m_mode == M_SET));
            check("locked_out", 32'(locked_out), 32'(m_mode == M_LOCK));
            check("setting", 32'(setting), 32'(m_mode == M_SET));
        end
    end

    task automatic tick(input bit v, input logic [3:0] k);
        key_valid = v;
        key_code  = k;
        @(posedge CLK);
        #1;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) tick(1'b1, c[15-4*i -: 4]);
        tick(1'b1, 4'hB);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_display"}, 32'(display), 32'hFFFF);
        check({tag, "_count"}, 32'(digit_count), 32'd0);
        check({tag, "_err"}, 32'(error_count), 32'd0);
        check({tag, "_unlocked"}, 32'(unlocked), 32'd0);
        check({tag, "_locked"}, 32'(locked_out), 32'd0);
        check({tag, "_setting"}, 32'(setting), 32'd0);
    endtask

    int r;
    int n;

    initial begin
        RST = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;
        @(posedge CLK);
        #1;
        tick(1'b0, 4'h0);
        chk_en = 1'b1;
        check_reset_values("por");
        RST = 1'b0;

        // Correct default code: CHECK one cycle after Enter, unlock the cycle after.
        enter_code(16'h1234);
        check("chk_cycle_display", 32'(display), 32'h1234);
        check("chk_cycle_unlocked", 32'(unlocked), 32'd0);
        tick(1'b0, 4'h0);
        check("unlock_1", 32'(unlocked), 32'd1);
        check("unlock_display", 32'(display), 32'hFFFF);
        tick(1'b1, 4'hD);
        check("relock_d", 32'(unlocked), 32'd0);

        // Three wrong codes lead to lockout, which expires after LOCK_C cycles.
        for (int t = 0; t < MAX_TRIES; t++) begin
            enter_code(16'h1235);
            tick(1'b0, 4'h0);
            check("wrong_err", 32'(error_count), 32'(t + 1));
        end
        check("lockout_on", 32'(locked_out), 32'd1);
        enter_code(16'h1234);
        check("lockout_keys_ignored", 32'(display), 32'hFFFF);
        repeat (14) tick(1'b0, 4'h0);
        check("lockout_still", 32'(locked_out), 32'd1);
        tick(1'b0, 4'h0);
        check("lockout_end", 32'(locked_out), 32'd0);
        check("lockout_err_clr", 32'(error_count), 32'd0);

        // Short entry ignored, overflow digit dropped.
        tick(1'b1, 4'h1); tick(1'b1, 4'h2); tick(1'b1, 4'hB);
        check("short_display", 32'(display), 32'hFF12);
        check("short_count", 32'(digit_count), 32'd2);
        tick(1'b1, 4'h3); tick(1'b1, 4'h4); tick(1'b1, 4'h5);
        check("full_display", 32'(display), 32'h1234);
        check("full_count", 32'(digit_count), 32'd4);
        tick(1'b1, 4'hB); tick(1'b0, 4'h0);
        check("unlock_2", 32'(unlocked), 32'd1);

        // Change code to 9876.
        tick(1'b1, 4'hC);
        check("set_on", 32'(setting), 32'd1);
        enter_code(16'h9876);
        check("set_done", 32'(setting), 32'd0);
        check("set_open", 32'(unlocked), 32'd1);
        tick(1'b1, 4'hD);
        enter_code(16'h1234); tick(1'b0, 4'h0);
        check("old_code_err", 32'(error_count), 32'd1);
        check("old_code_locked", 32'(unlocked), 32'd0);
        enter_code(16'h9876); tick(1'b0, 4'h0);
        check("new_code_unlock", 32'(unlocked), 32'd1);

        // Auto relock exactly OPEN_C cycles after unlock.
        repeat (OPEN_C - 1) tick(1'b0, 4'h0);
        check("open_before_expiry", 32'(unlocked), 32'd1);
        tick(1'b0, 4'h0);
        check("open_expired", 32'(unlocked), 32'd0);

        // D on the same edge as expiry.
        enter_code(16'h9876); tick(1'b0, 4'h0);
        repeat (OPEN_C - 1) tick(1'b0, 4'h0);
        tick(1'b1, 4'hD);
        check("d_at_expiry", 32'(unlocked), 32'd0);
        tick(1'b1, 4'h7);
        check("entry_after_expiry", 32'(display), 32'hFFF7);
        tick(1'b1, 4'hA);

        // Reset during lockout, with a key strobe in the same cycle.
        for (int t = 0; t < MAX_TRIES; t++) begin
            enter_code(16'h1235);
            tick(1'b0, 4'h0);
        end
        check("lock_before_rst", 32'(locked_out), 32'd1);
        RST = 1'b1;
        tick(1'b1, 4'h1);
        RST = 1'b0;
        check_reset_values("rst_lock");
        enter_code(16'h1234); tick(1'b0, 4'h0);
        check("rst_default_code", 32'(unlocked), 32'd1);

        // Reset during SET.
        tick(1'b1, 4'hC); tick(1'b1, 4'h5); tick(1'b1, 4'h5);
        check("set_before_rst", 32'(setting), 32'd1);
        RST = 1'b1;
        tick(1'b0, 4'h0);
        RST = 1'b0;
        check_reset_values("rst_set");
        enter_code(16'h1234); tick(1'b0, 4'h0);
        check("rst_set_unlock", 32'(unlocked), 32'd1);
        tick(1'b1, 4'hD);

        // Random traffic; correct-code bursts use the model's current code.
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                RST = 1'b1;
                tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                RST = 1'b0;
            end else if (r < 22) begin
                for (int i = 0; i < DIGITS; i++) tick(1'b1, 4'(m_code[i]));
                tick(1'b1, 4'hB);
            end else if (r < 40) begin
                n = $urandom_range(0, 5);
                for (int i = 0; i < n; i++) tick(1'b1, 4'($urandom_range(0, 9)));
                tick(1'b1, 4'hB);
            end else if (r < 55) begin
                tick(1'b1, 4'($urandom_range(10, 15)));
            end else if (r < 70) begin
                tick(1'b1, 4'($urandom_range(0, 15)));
            end else begin
                repeat ($urandom_range(1, 12)) tick(1'b0, 4'h0);
            end
        end
        tick(1'b0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
